pu_rf_mp: RTL

Parametrised multi-port register file for the packet-processing unit. It generalises the 2-read/1-write register file to NRD read ports and NWR write ports, and adds:
- optional write-to-read bypass
- an optional hardwired-zero register 0
- a per-register reset-value table
- a pending-load scoreboard, so the PU pipeline can detect reads of registers whose load result has not yet returned

It sits between PU decode (read ports, scoreboard set) and the PU execute/memory write-back stages (write ports).

---
 rtl/pu_rf_mp.sv | 80 ++++++++
 1 files changed

// File: rtl/pu_rf_mp.sv
// pu_rf_mp: multi-port register file with priority write ports, optional bypass,
// optional hardwired-zero r0, per-register reset values and a pending-load scoreboard
module pu_rf_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH_NBITS = 5,
  parameter int NRD = 3,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  parameter int R0_ZERO = 0,
  parameter logic [(2**DEPTH_NBITS)*WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NWR-1:0]               wr,
  input  logic [NWR*DEPTH_NBITS-1:0]   waddr,
  input  logic [NWR*WIDTH-1:0]         din,
  input  logic [NRD-1:0]               rd_en,
  input  logic [NRD*DEPTH_NBITS-1:0]   raddr,
  output logic [NRD*WIDTH-1:0]         dout,
  output logic [NRD-1:0]               dout_valid,
  output logic [NRD-1:0]               rd_busy,
  input  logic                         busy_set,
  input  logic [DEPTH_NBITS-1:0]       busy_addr,
  output logic [(2**DEPTH_NBITS)-1:0]  busy_vec
);
  localparam int DEPTH = 2**DEPTH_NBITS;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [NRD*WIDTH-1:0] r_dout;
  logic [NRD-1:0] r_dv, r_rb;
  logic [DEPTH-1:0] w_hit;
  logic [WIDTH-1:0] w_wdat [DEPTH];
  logic [WIDTH-1:0] w_rdat [NRD];
  logic [NRD-1:0] w_rbusy;
  // later ports overwrite earlier ones, so the highest-index writer wins
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = 1'b0;
      w_wdat[i] = r_mem[i];
      for (int p = 0; p < NWR; p++)
        if (wr[p] && waddr[p*DEPTH_NBITS +: DEPTH_NBITS] == DEPTH_NBITS'(i) && !(R0_ZERO != 0 && i == 0)) begin
          w_hit[i] = 1'b1;
          w_wdat[i] = din[p*WIDTH +: WIDTH];
        end
    end
  end
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      w_rdat[k] = (BYPASS != 0) ? w_wdat[raddr[k*DEPTH_NBITS +: DEPTH_NBITS]] : r_mem[raddr[k*DEPTH_NBITS +: DEPTH_NBITS]];
      w_rbusy[k] = r_busy[raddr[k*DEPTH_NBITS +: DEPTH_NBITS]] & ~((BYPASS != 0) & w_hit[raddr[k*DEPTH_NBITS +: DEPTH_NBITS]]);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= (R0_ZERO != 0 && i == 0) ? '0 : RST_VAL[i*WIDTH +: WIDTH];
    else
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_wdat[i];
  // a new load issued alongside a write-back keeps the register busy
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_busy <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        r_busy[i] <= !(R0_ZERO != 0 && i == 0) && ((busy_set && busy_addr == DEPTH_NBITS'(i)) || (r_busy[i] && !w_hit[i]));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dout <= '0;
      r_dv <= '0;
      r_rb <= '0;
    end else begin
      r_dv <= rd_en;
      r_rb <= rd_en & w_rbusy;
      for (int k = 0; k < NRD; k++)
        if (rd_en[k]) r_dout[k*WIDTH +: WIDTH] <= w_rdat[k];
    end
  assign dout = r_dout;
  assign dout_valid = r_dv;
  assign rd_busy = r_rb;
  assign busy_vec = r_busy;
endmodule
